// File: rtl/cdb_pkg.sv
// Shared CDB constants: default unit count, grant-index width derivation, grant-counter width.
// Pure declarations, no latency; no flow control of its own.
// Imported by cdb_arbiter, its pick sub-module and functional_unit_output_buffer.
package cdb_pkg;

    localparam int N_UNITS_DEF = 4;
    localparam int GRANT_CNT_W = 32;

    // A 2-unit arbiter still needs one index bit, which $clog2 alone would also give,
    // but guarding keeps degenerate sizes from producing a zero-width index.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB arbitration bundle: per-unit requests and stall in, one-hot permit, valid and index out.
// Purely wiring, no latency; stall is carried to the arbiter, which suppresses all grants.
// master = requester / CDB side, slave = arbiter.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int N_UNITS   = N_UNITS_DEF,
    parameter int IDX_WIDTH = idx_width(N_UNITS)
);

    logic [N_UNITS-1:0]   not_empty;
    logic                 cdb_stall;
    logic [N_UNITS-1:0]   cdb_permit;
    logic                 cdb_valid;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH-1:0] rr_ptr;

    modport master (
        output not_empty,
        output cdb_stall,
        input  cdb_permit,
        input  cdb_valid,
        input  grant_idx,
        input  rr_ptr
    );

    modport slave (
        input  not_empty,
        input  cdb_stall,
        output cdb_permit,
        output cdb_valid,
        output grant_idx,
        output rr_ptr
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating first-one picker: first set request at or above start, wrapping to 0.
// Purely combinational, zero latency.
// No backpressure; the caller masks the result.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N_UNITS   = N_UNITS_DEF,
    parameter int IDX_WIDTH = idx_width(N_UNITS)
) (
    input  logic [N_UNITS-1:0]   req,
    input  logic [IDX_WIDTH-1:0] start,
    output logic [N_UNITS-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    always_comb begin
        int u;
        u   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_UNITS; k++) begin
            u = int'(start) + k;
            if (u >= N_UNITS) u = u - N_UNITS;
            if (!any && req[u]) begin
                any    = 1'b1;
                gnt[u] = 1'b1;
                idx    = u[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter; optional per-unit saturating grant counters under CDB_ARBITER_GRANT_COUNT_EN.
// Zero-cycle grant from not_empty/cdb_stall/reset and the registered rr_ptr.
// cdb_stall or reset withdraws every grant and freezes/clears rr_ptr.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_UNITS   = N_UNITS_DEF,
    parameter int IDX_WIDTH = idx_width(N_UNITS)
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CDB_ARBITER_GRANT_COUNT_EN
    output logic [N_UNITS*GRANT_CNT_W-1:0] grant_count,
`endif
    cdb_arbiter_if.slave       bus
);

    logic [N_UNITS-1:0]   pick_gnt;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_any;
    logic                 grant_en;
    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic [IDX_WIDTH-1:0] rr_ptr_nxt;

    rr_pick #(
        .N_UNITS   (N_UNITS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (bus.not_empty),
        .start (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign grant_en       = pick_any && !bus.cdb_stall && !reset;
    assign bus.cdb_permit = grant_en ? pick_gnt : '0;
    assign bus.cdb_valid  = grant_en;
    assign bus.grant_idx  = grant_en ? pick_idx : '0;
    assign bus.rr_ptr     = rr_ptr_q;

    // Priority moves to the unit just after the winner, which gives the fairness bound.
    assign rr_ptr_nxt = (bus.grant_idx == IDX_WIDTH'(N_UNITS - 1)) ? '0
                                                                   : bus.grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr_q <= '0;
        else if (bus.cdb_valid)
            rr_ptr_q <= rr_ptr_nxt;
    end

`ifdef CDB_ARBITER_GRANT_COUNT_EN
    logic [GRANT_CNT_W-1:0] cnt_q [N_UNITS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (reset)
                cnt_q[i] <= '0;
            else if (bus.cdb_permit[i] && (cnt_q[i] != '1))
                cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_UNITS; g++) begin : g_cnt
        assign grant_count[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[g];
    end
`endif

endmodule
